aes_mix_column_iter: RTL and testbench

AES_MIX_COLUMN_ITER -- requirements
Module: aes_mix_column_iter

---
 rtl/aes_mix_column_iter_if.sv | 34 +++
 rtl/aes_mix_column_iter.sv | 121 ++++++++++++
 tb/tb_aes_mix_column_iter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mix_column_iter_if.sv
// Handshake and data bundle for the iterative AES (Inv)MixColumns unit.
// slave = the transform block; master = the side that offers blocks and takes results.
interface aes_mix_column_iter_if;
  logic         i_aes_mix_column_valid;
  logic         o_aes_mix_column_ready;
  logic         i_aes_mix_column_inverse;
  logic [127:0] i_aes_mix_column_data_in;
  logic         o_aes_mix_column_valid;
  logic         i_aes_mix_column_ready;
  logic [127:0] o_aes_mix_column_data_out;
  logic         o_aes_mix_column_busy;

  modport slave (
    input  i_aes_mix_column_valid,
    input  i_aes_mix_column_inverse,
    input  i_aes_mix_column_data_in,
    input  i_aes_mix_column_ready,
    output o_aes_mix_column_ready,
    output o_aes_mix_column_valid,
    output o_aes_mix_column_data_out,
    output o_aes_mix_column_busy
  );

  modport master (
    output i_aes_mix_column_valid,
    output i_aes_mix_column_inverse,
    output i_aes_mix_column_data_in,
    output i_aes_mix_column_ready,
    input  o_aes_mix_column_ready,
    input  o_aes_mix_column_valid,
    input  o_aes_mix_column_data_out,
    input  o_aes_mix_column_busy
  );
endinterface

// File: rtl/aes_mix_column_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE
// columns per cycle, transformed in place in a working register.
module aes_mix_column_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  aes_mix_column_iter_if.slave bus
);
  localparam int NCYC = 4 / COLS_PER_CYCLE;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("aes_mix_column_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   cnt_reg;
  logic [127:0] work_reg, work_next;
  logic         mode_reg;
  logic         ready, valid, busy, accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      else
        res[31-8*r -: 8] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  // Column view of the working register; column 0 is the MSB word.
  logic [31:0] words      [4];
  logic [31:0] words_next [4];
  logic [1:0]  col_idx    [COLS_PER_CYCLE];
  logic [31:0] col_mixed  [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign words[gi]                  = work_reg[127-32*gi -: 32];
    assign work_next[127-32*gi -: 32] = words_next[gi];
  end

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_mixers
    assign col_idx[gi]   = 2'(int'(cnt_reg) * COLS_PER_CYCLE + gi);
    assign col_mixed[gi] = mix_column(words[col_idx[gi]], mode_reg);
  end

  always_comb begin
    words_next = words;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      words_next[col_idx[g]] = col_mixed[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.i_aes_mix_column_valid) state_next = BUSY;
      BUSY: if (cnt_reg == 2'(NCYC - 1))    state_next = DONE;
      DONE: if (bus.i_aes_mix_column_ready)
              state_next = bus.i_aes_mix_column_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result handoff in DONE lets the next block load on the same edge it leaves.
  always_comb begin
    ready = (state_reg == IDLE) | ((state_reg == DONE) & bus.i_aes_mix_column_ready);
    valid = (state_reg == DONE);
    busy  = (state_reg == BUSY);
  end

  assign accept = bus.i_aes_mix_column_valid & ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_reg <= '0;
      mode_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      work_reg <= bus.i_aes_mix_column_data_in;
      mode_reg <= bus.i_aes_mix_column_inverse;
      cnt_reg  <= '0;
    end else if (state_reg == BUSY) begin
      work_reg <= work_next;
      cnt_reg  <= cnt_reg + 2'd1;
    end
  end

  assign bus.o_aes_mix_column_ready    = ready;
  assign bus.o_aes_mix_column_valid    = valid;
  assign bus.o_aes_mix_column_busy     = busy;
  assign bus.o_aes_mix_column_data_out = work_reg;
endmodule

// File: tb/tb_aes_mix_column_iter.sv
// Self-checking bench for aes_mix_column_iter: directed vectors, back-pressure,
// reset abort, back-to-back handoff and a randomized run against a GF(2^8) matrix model.
module tb_aes_mix_column_iter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  aes_mix_column_iter_if bus1 ();
  aes_mix_column_iter_if bus2 ();
  aes_mix_column_iter_if bus4 ();

  aes_mix_column_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  aes_mix_column_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  aes_mix_column_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;

  // Plain polynomial multiply then reduce modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Each output column is the circulant coefficient row times the input column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], a[(r+k)%4]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one block through dut1 with a stall of 'stall' cycles in DONE, scribbling
  // on the inputs while the block is in flight. lat counts edges from accept to valid.
  task automatic run_block(input logic [127:0] d, input logic inv, input int stall,
                           output logic [127:0] first, output logic [127:0] got,
                           output int lat, output bit hs_ok);
    int guard;
    hs_ok = 1'b1;
    lat   = 0;
    first = '0;
    got   = '0;
    @(negedge clk);
    bus1.i_aes_mix_column_valid   = 1'b1;
    bus1.i_aes_mix_column_data_in = d;
    bus1.i_aes_mix_column_inverse = inv;
    bus1.i_aes_mix_column_ready   = 1'b0;
    #1;
    guard = 0;
    while (!bus1.o_aes_mix_column_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!bus1.o_aes_mix_column_ready) hs_ok = 1'b0;
    @(negedge clk);
    bus1.i_aes_mix_column_valid   = 1'($urandom_range(0, 1));
    bus1.i_aes_mix_column_data_in = rand128();
    bus1.i_aes_mix_column_inverse = 1'($urandom_range(0, 1));
    while (!bus1.o_aes_mix_column_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!bus1.o_aes_mix_column_valid) hs_ok = 1'b0;
    first = bus1.o_aes_mix_column_data_out;
    repeat (stall) @(negedge clk);
    got = bus1.o_aes_mix_column_data_out;
    bus1.i_aes_mix_column_valid = 1'b0;
    bus1.i_aes_mix_column_ready = 1'b1;
    @(negedge clk);
    bus1.i_aes_mix_column_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus1.o_aes_mix_column_valid !== 1'b0)
      $display("FAIL reset_valid got=%b exp=0", bus1.o_aes_mix_column_valid);
    else n_pass++;
    n_checks++;
    if (bus1.o_aes_mix_column_busy !== 1'b0)
      $display("FAIL reset_busy got=%b exp=0", bus1.o_aes_mix_column_busy);
    else n_pass++;
    n_checks++;
    if (bus1.o_aes_mix_column_data_out !== 128'h0)
      $display("FAIL reset_data got=%h exp=0", bus1.o_aes_mix_column_data_out);
    else n_pass++;
    n_checks++;
    if (bus1.o_aes_mix_column_ready !== 1'b1 || bus2.o_aes_mix_column_ready !== 1'b1 ||
        bus4.o_aes_mix_column_ready !== 1'b1)
      $display("FAIL reset_ready got=%b%b%b exp=111", bus1.o_aes_mix_column_ready,
               bus2.o_aes_mix_column_ready, bus4.o_aes_mix_column_ready);
    else n_pass++;
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_known_vectors();
    logic [127:0] first, got, d, e;
    int lat;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? VEC_A : (t == 1) ? VEC_B : {32'h4d7ebdf8, 96'h0};
      e = (t == 0) ? VEC_B : (t == 1) ? VEC_A : {32'h2d26314c, 96'h0};
      run_block(d, (t != 0), 0, first, got, lat, ok);
      $display("known[%0d]: in=%h inv=%0d out=%h lat=%0d", t, d, (t != 0), got, lat);
      n_checks++;
      if (got !== e) $display("FAIL known_data[%0d] got=%h exp=%h", t, got, e);
      else n_pass++;
      n_checks++;
      if (!ok || lat != 4) $display("FAIL known_latency[%0d] got=%0d exp=4", t, lat);
      else n_pass++;
    end
  endtask

  task automatic test_cols2();
    int lat;
    @(negedge clk);
    bus2.i_aes_mix_column_valid   = 1'b1;
    bus2.i_aes_mix_column_data_in = VEC_A;
    bus2.i_aes_mix_column_inverse = 1'b0;
    bus2.i_aes_mix_column_ready   = 1'b0;
    @(negedge clk);
    bus2.i_aes_mix_column_valid = 1'b0;
    lat = 0;
    while (!bus2.o_aes_mix_column_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    $display("cols2: out=%h lat=%0d", bus2.o_aes_mix_column_data_out, lat);
    n_checks++;
    if (bus2.o_aes_mix_column_data_out !== VEC_B)
      $display("FAIL cols2_data got=%h exp=%h", bus2.o_aes_mix_column_data_out, VEC_B);
    else n_pass++;
    n_checks++;
    if (lat != 2) $display("FAIL cols2_latency got=%0d exp=2", lat);
    else n_pass++;
    bus2.i_aes_mix_column_ready = 1'b1;
    @(negedge clk);
    bus2.i_aes_mix_column_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] d2, e2;
    int lat;
    d2 = rand128();
    e2 = ref_mix(d2, 1'b1);
    @(negedge clk);
    bus1.i_aes_mix_column_valid   = 1'b1;
    bus1.i_aes_mix_column_data_in = VEC_A;
    bus1.i_aes_mix_column_inverse = 1'b0;
    bus1.i_aes_mix_column_ready   = 1'b0;
    @(negedge clk);
    bus1.i_aes_mix_column_valid = 1'b0;
    lat = 0;
    while (!bus1.o_aes_mix_column_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    bus1.i_aes_mix_column_valid   = 1'b1;
    bus1.i_aes_mix_column_data_in = d2;
    bus1.i_aes_mix_column_inverse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus1.o_aes_mix_column_valid !== 1'b1 || bus1.o_aes_mix_column_ready !== 1'b0 ||
          bus1.o_aes_mix_column_data_out !== VEC_B)
        $display("FAIL stall[%0d] got valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h", i,
                 bus1.o_aes_mix_column_valid, bus1.o_aes_mix_column_ready,
                 bus1.o_aes_mix_column_data_out, VEC_B);
      else n_pass++;
      @(negedge clk);
    end
    bus1.i_aes_mix_column_ready = 1'b1;
    #1;
    n_checks++;
    if (bus1.o_aes_mix_column_ready !== 1'b1)
      $display("FAIL handoff_ready got=%b exp=1", bus1.o_aes_mix_column_ready);
    else n_pass++;
    @(negedge clk);
    bus1.i_aes_mix_column_valid = 1'b0;
    bus1.i_aes_mix_column_ready = 1'b0;
    n_checks++;
    if (bus1.o_aes_mix_column_busy !== 1'b1 || bus1.o_aes_mix_column_valid !== 1'b0)
      $display("FAIL handoff_busy got busy=%b valid=%b exp busy=1 valid=0",
               bus1.o_aes_mix_column_busy, bus1.o_aes_mix_column_valid);
    else n_pass++;
    lat = 0;
    while (!bus1.o_aes_mix_column_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    $display("backpressure: second out=%h lat=%0d", bus1.o_aes_mix_column_data_out, lat);
    n_checks++;
    if (bus1.o_aes_mix_column_data_out !== e2 || lat != 4)
      $display("FAIL handoff_result got=%h lat=%0d exp=%h lat=4",
               bus1.o_aes_mix_column_data_out, lat, e2);
    else n_pass++;
    bus1.i_aes_mix_column_ready = 1'b1;
    @(negedge clk);
    bus1.i_aes_mix_column_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] first, got;
    int lat;
    bit ok;
    @(negedge clk);
    bus1.i_aes_mix_column_valid   = 1'b1;
    bus1.i_aes_mix_column_data_in = rand128();
    bus1.i_aes_mix_column_inverse = 1'b0;
    @(negedge clk);
    bus1.i_aes_mix_column_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus1.o_aes_mix_column_valid !== 1'b0 || bus1.o_aes_mix_column_busy !== 1'b0 ||
        bus1.o_aes_mix_column_data_out !== 128'h0 || bus1.o_aes_mix_column_ready !== 1'b1)
      $display("FAIL abort got valid=%b busy=%b data=%h ready=%b exp 0 0 0 1",
               bus1.o_aes_mix_column_valid, bus1.o_aes_mix_column_busy,
               bus1.o_aes_mix_column_data_out, bus1.o_aes_mix_column_ready);
    else n_pass++;
    rst_n = 1'b1;
    run_block({16{8'hc6}}, 1'b0, 0, first, got, lat, ok);
    $display("reset_mid: post-reset out=%h lat=%0d", got, lat);
    n_checks++;
    if (got !== {16{8'hc6}} || !ok || lat != 4)
      $display("FAIL after_abort got=%h lat=%0d exp=%h lat=4", got, lat, {16{8'hc6}});
    else n_pass++;
  endtask

  // dut4 with ready tied high: each result is handed off the same cycle the next block loads.
  task automatic test_back_to_back();
    logic [127:0] d   [3];
    logic         inv [3];
    logic [127:0] exp_q [$];
    logic [127:0] e;
    int idx, n_out, cyc, acc_cyc, last_out;
    bit acc_now;
    d[0] = VEC_A;     inv[0] = 1'b0;
    d[1] = VEC_B;     inv[1] = 1'b1;
    d[2] = rand128(); inv[2] = 1'b0;
    idx = 0; n_out = 0; cyc = 0; acc_cyc = 0; last_out = 0;
    @(negedge clk);
    bus4.i_aes_mix_column_ready   = 1'b1;
    bus4.i_aes_mix_column_valid   = 1'b1;
    bus4.i_aes_mix_column_data_in = d[0];
    bus4.i_aes_mix_column_inverse = inv[0];
    while (n_out < 3 && cyc < 40) begin
      #1;
      acc_now = 1'b0;
      if (bus4.o_aes_mix_column_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        $display("b2b: out[%0d]=%h cyc=%0d", n_out, bus4.o_aes_mix_column_data_out, cyc);
        n_checks++;
        if (bus4.o_aes_mix_column_data_out !== e)
          $display("FAIL b2b_data[%0d] got=%h exp=%h", n_out, bus4.o_aes_mix_column_data_out, e);
        else n_pass++;
        // Accept decided at negedge a loads on the next edge; valid is seen NCYC edges later.
        n_checks++;
        if (n_out == 0 && cyc - acc_cyc != 2)
          $display("FAIL b2b_latency got=%0d exp=2", cyc - acc_cyc);
        else if (n_out > 0 && cyc - last_out != 2)
          $display("FAIL b2b_spacing[%0d] got=%0d exp=2", n_out, cyc - last_out);
        else n_pass++;
        last_out = cyc;
        n_out++;
      end
      if (bus4.i_aes_mix_column_valid && bus4.o_aes_mix_column_ready) begin
        exp_q.push_back(ref_mix(d[idx], inv[idx]));
        if (idx == 0) acc_cyc = cyc;
        idx++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (idx < 3) begin
          bus4.i_aes_mix_column_data_in = d[idx];
          bus4.i_aes_mix_column_inverse = inv[idx];
        end else begin
          bus4.i_aes_mix_column_valid = 1'b0;
        end
      end
    end
    n_checks++;
    if (n_out != 3) $display("FAIL b2b_count got=%0d exp=3", n_out);
    else n_pass++;
    bus4.i_aes_mix_column_valid = 1'b0;
    bus4.i_aes_mix_column_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] d, first, got, first2, got2;
    logic inv;
    int lat, lat2;
    bit ok, ok2;
    for (int i = 0; i < 1000; i++) begin
      d   = rand128();
      inv = 1'($urandom_range(0, 1));
      run_block(d, inv, $urandom_range(0, 3), first, got, lat, ok);
      $display("rand[%0d]: in=%h inv=%0d out=%h", i, d, inv, got);
      n_checks++;
      if (!ok || lat != 4) $display("FAIL rand_latency[%0d] got=%0d exp=4", i, lat);
      else n_pass++;
      n_checks++;
      if (got !== first) $display("FAIL rand_hold[%0d] got=%h exp=%h", i, got, first);
      else n_pass++;
      n_checks++;
      if (got !== ref_mix(d, inv))
        $display("FAIL rand_data[%0d] got=%h exp=%h", i, got, ref_mix(d, inv));
      else n_pass++;
      if (i % 8 == 0) begin
        run_block(got, ~inv, 0, first2, got2, lat2, ok2);
        n_checks++;
        if (!ok2 || got2 !== d) $display("FAIL round_trip[%0d] got=%h exp=%h", i, got2, d);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus1.i_aes_mix_column_valid = 1'b0; bus1.i_aes_mix_column_ready = 1'b0;
    bus1.i_aes_mix_column_inverse = 1'b0; bus1.i_aes_mix_column_data_in = '0;
    bus2.i_aes_mix_column_valid = 1'b0; bus2.i_aes_mix_column_ready = 1'b0;
    bus2.i_aes_mix_column_inverse = 1'b0; bus2.i_aes_mix_column_data_in = '0;
    bus4.i_aes_mix_column_valid = 1'b0; bus4.i_aes_mix_column_ready = 1'b0;
    bus4.i_aes_mix_column_inverse = 1'b0; bus4.i_aes_mix_column_data_in = '0;
    test_reset();
    test_known_vectors();
    test_cols2();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired got=%0d/%0d checks", n_pass, n_checks);
    $fatal(1, "timeout");
  end
endmodule
